// File: rtl/shared_bus_ctrl.sv
// Shared bus controller: arbitrates N_SRC sources onto one registered bus
// (fixed priority or round-robin) and counts cycles with competing requests.
module shared_bus_ctrl #(
    parameter int DATA_W = 16,
    parameter int N_SRC  = 12,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        read_en,
    input  logic                    clr_cnt,
    output logic [DATA_W-1:0]       bus,
    output logic                    bus_valid,
    output logic [N_SRC-1:0]        grant,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SRC - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        base_s;
    logic [2*N_SRC-1:0]      dbl_s;
    logic [N_SRC-1:0]        rot_s;
    logic [PTR_W-1:0]        off_s;
    logic                    found_s;
    logic [PTR_W:0]          sum_s;
    logic [PTR_W-1:0]        win_idx_s;
    logic [N_SRC-1:0]        grant_s;
    logic [DATA_W-1:0]       word_s;
    logic                    multi_s;

    // Search start: index 0 for fixed priority, one past the last winner for round-robin.
    always_comb begin
        base_s = '0;
        if (MODE == 0) begin
            base_s = '0;
        end else if (rr_ptr_r == LAST_IDX) begin
            base_s = '0;
        end else begin
            base_s = rr_ptr_r + PTR_W'(1);
        end
    end

    // Rotate requests so the search start sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s   = {read_en, read_en};
        rot_s   = N_SRC'(dbl_s >> base_s);
        found_s = 1'b0;
        off_s   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            off_s   = rot_s[i] ? PTR_W'(i) : off_s;
            found_s = found_s | rot_s[i];
        end
    end

    // Undo the rotation to recover the absolute winner index.
    always_comb begin
        sum_s     = {1'b0, base_s} + {1'b0, off_s};
        win_idx_s = '0;
        if (sum_s >= N_WIDE) begin
            win_idx_s = PTR_W'(sum_s - N_WIDE);
        end else begin
            win_idx_s = sum_s[PTR_W-1:0];
        end
    end

    // One-hot grant, AND-OR data mux (only the granted word can reach the bus), conflict detect.
    always_comb begin
        grant_s = '0;
        if (found_s) begin
            grant_s = N_SRC'(1) << win_idx_s;
        end else begin
            grant_s = '0;
        end
        word_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            word_s = word_s | (src_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
        multi_s = |(read_en & (read_en - N_SRC'(1)));
    end

    // Registered bus outputs and round-robin pointer; the bus holds when nobody requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus       <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            conflict  <= 1'b0;
            rr_ptr_r  <= LAST_IDX;
        end else begin
            bus_valid <= found_s;
            grant     <= grant_s;
            conflict  <= multi_s;
            if (found_s) begin
                bus      <= word_s;
                rr_ptr_r <= win_idx_s;
            end
        end
    end

    // Saturating conflict counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (clr_cnt) begin
            conflict_cnt <= '0;
        end else if (multi_s && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shared_bus_ctrl.sv
// Bench for shared_bus_ctrl: three instances (fixed priority, round-robin,
// fixed priority with a 2-bit counter) driven in parallel against a reference model.
module tb_shared_bus_ctrl;

    localparam int N = 12;
    localparam int D = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*D-1:0] src_data = '0;
    logic [N-1:0]   read_en = '0;
    logic           clr_cnt = 1'b0;

    logic [D-1:0] bus_w   [3];
    logic         valid_w [3];
    logic [N-1:0] grant_w [3];
    logic         conf_w  [3];
    logic [7:0]   cnt0, cnt1;
    logic [1:0]   cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           mode_of [3] = '{0, 1, 0};
    int           cnt_max [3] = '{255, 255, 3};
    int           m_rr    [3];
    logic [D-1:0] m_bus   [3];
    logic [N-1:0] m_grant [3];
    logic         m_valid [3];
    logic         m_conf  [3];
    int           m_cnt   [3];

    shared_bus_ctrl #(.DATA_W(D), .N_SRC(N), .MODE(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .read_en(read_en), .clr_cnt(clr_cnt),
        .bus(bus_w[0]), .bus_valid(valid_w[0]), .grant(grant_w[0]), .conflict(conf_w[0]),
        .conflict_cnt(cnt0));

    shared_bus_ctrl #(.DATA_W(D), .N_SRC(N), .MODE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .read_en(read_en), .clr_cnt(clr_cnt),
        .bus(bus_w[1]), .bus_valid(valid_w[1]), .grant(grant_w[1]), .conflict(conf_w[1]),
        .conflict_cnt(cnt1));

    shared_bus_ctrl #(.DATA_W(D), .N_SRC(N), .MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .read_en(read_en), .clr_cnt(clr_cnt),
        .bus(bus_w[2]), .bus_valid(valid_w[2]), .grant(grant_w[2]), .conflict(conf_w[2]),
        .conflict_cnt(cnt2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int d);
        case (d)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    // Winner: lowest index, or first requester found scanning upward from ptr+1 with wrap.
    function automatic int pick(input int md, input int ptr, input logic [N-1:0] re);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (md == 0) ? (k - 1) : ((ptr + k) % N);
            if (re[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_rr[d]    = N - 1;
            m_bus[d]   = '0;
            m_grant[d] = '0;
            m_valid[d] = 1'b0;
            m_conf[d]  = 1'b0;
            m_cnt[d]   = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int w;
            w = pick(mode_of[d], m_rr[d], read_en);
            m_conf[d] = ($countones(read_en) >= 2);
            if (w >= 0) begin
                m_bus[d]   = src_data[w*D +: D];
                m_grant[d] = N'(1) << w;
                m_valid[d] = 1'b1;
                m_rr[d]    = w;
            end else begin
                m_grant[d] = '0;
                m_valid[d] = 1'b0;
            end
            if (clr_cnt) m_cnt[d] = 0;
            else if (m_conf[d] && m_cnt[d] < cnt_max[d]) m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    task automatic check_all(input string ph);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s bus%0d", ph, d),    32'(bus_w[d]),   32'(m_bus[d]));
            chk($sformatf("%s grant%0d", ph, d),  32'(grant_w[d]), 32'(m_grant[d]));
            chk($sformatf("%s valid%0d", ph, d),  32'(valid_w[d]), 32'(m_valid[d]));
            chk($sformatf("%s conf%0d", ph, d),   32'(conf_w[d]),  32'(m_conf[d]));
            chk($sformatf("%s cnt%0d", ph, d),    get_cnt(d),      32'(m_cnt[d]));
            chk($sformatf("%s onehot%0d", ph, d), 32'($onehot0(grant_w[d])), 32'd1);
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle(input string ph);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        logic [1:0]   sat_exp [5];
        rr_exp  = '{12'h001, 12'h080, 12'h800, 12'h001};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        #2;
        model_reset();
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Two competing requesters, lowest index wins
        read_en = 12'h00C;
        src_data[2*D +: D] = 16'hAAAA;
        src_data[3*D +: D] = 16'h5555;
        cycle("r031");
        chk("r031 bus",   32'(bus_w[0]),   32'h0000_AAAA);
        chk("r031 grant", 32'(grant_w[0]), 32'h0000_0004);
        chk("r031 valid", 32'(valid_w[0]), 32'd1);
        chk("r031 conf",  32'(conf_w[0]),  32'd1);
        chk("r031 cnt",   32'(cnt0),       32'd1);
        read_en = '0;

        // Round-robin rotation after reset
        apply_reset();
        read_en = 12'h881;
        for (int i = 0; i < 4; i++) begin
            cycle("r032");
            chk($sformatf("r032 grant step%0d", i), 32'(grant_w[1]), 32'(rr_exp[i]));
        end
        chk("r032 cnt", 32'(cnt1), 32'd4);

        // Bus holds after the requester drops
        read_en = 12'h010;
        src_data[4*D +: D] = 16'h1234;
        cycle("r033a");
        chk("r033 bus0",   32'(bus_w[0]),   32'h0000_1234);
        chk("r033 valid0", 32'(valid_w[0]), 32'd1);
        chk("r033 grant0", 32'(grant_w[0]), 32'h0000_0010);
        read_en = '0;
        for (int i = 0; i < 3; i++) begin
            cycle("r033b");
            chk("r033 hold bus",   32'(bus_w[0]),   32'h0000_1234);
            chk("r033 hold valid", 32'(valid_w[0]), 32'd0);
            chk("r033 hold grant", 32'(grant_w[0]), 32'd0);
        end

        // Counter saturation and clear priority on the 2-bit instance
        clr_cnt = 1'b1;
        cycle("r034clr");
        clr_cnt = 1'b0;
        read_en = 12'h003;
        for (int i = 0; i < 5; i++) begin
            cycle("r034");
            chk($sformatf("r034 sat step%0d", i), 32'(cnt2), 32'(sat_exp[i]));
        end
        clr_cnt = 1'b1;
        cycle("r034b");
        chk("r034 clr cnt",  32'(cnt2),      32'd0);
        chk("r034 clr conf", 32'(conf_w[2]), 32'd1);
        clr_cnt = 1'b0;

        // Asynchronous reset between edges, then round-robin restarts at source 0
        apply_reset();
        for (int s = 0; s < N; s++) src_data[s*D +: D] = 16'hBEEF;
        read_en = 12'h003;
        for (int i = 0; i < 7; i++) cycle("r035pre");
        chk("r035 pre bus", 32'(bus_w[0]), 32'h0000_BEEF);
        chk("r035 pre cnt", 32'(cnt0),     32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("r035async");
        chk("r035 async bus", 32'(bus_w[1]), 32'd0);
        @(negedge clk);
        read_en = 12'hFFF;
        rst_n = 1'b1;
        cycle("r035post");
        chk("r035 first rr grant", 32'(grant_w[1]), 32'h0000_0001);

        // Randomised traffic
        for (int n = 0; n < 10000; n++) begin
            int kind;
            for (int s = 0; s < N; s++) src_data[s*D +: D] = D'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       read_en = '0;
                1:       read_en = N'(1) << $urandom_range(0, N - 1);
                default: read_en = N'($urandom);
            endcase
            clr_cnt = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_bus_ctrl.md
SHARED_BUS_CTRL -- requirements
Module: shared_bus_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of each source word and of the bus.
REQ-002 Parameter N_SRC, default 12, sets the number of bus sources (legal range 2..32).
REQ-003 Parameter MODE, default 0, selects arbitration: 0 = fixed priority, 1 = round-robin.
REQ-004 Parameter CNT_W, default 8, sets the width of the conflict counter.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port src_data, input, N_SRC*DATA_W bits: source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port read_en, input, N_SRC bits: bit i requests that source i drive the bus.
REQ-009 Port clr_cnt, input, 1 bit: synchronous clear of conflict_cnt.
REQ-010 Port bus, output, DATA_W bits: registered bus value.
REQ-011 Port bus_valid, output, 1 bit: a source was granted in the previous cycle.
REQ-012 Port grant, output, N_SRC bits: registered one-hot index of the source driving bus.
REQ-013 Port conflict, output, 1 bit: more than one read_en bit was high in the previous cycle.
REQ-014 Port conflict_cnt, output, CNT_W bits: saturating count of conflict cycles.

Function
REQ-015 Latency: the block SHALL register bus, grant, bus_valid and conflict exactly one clk edge after the sampled read_en and src_data.
REQ-016 In MODE 0, the block SHALL grant the lowest-indexed asserted read_en bit (index 0 has the highest priority).
REQ-017 In MODE 1, the block SHALL grant the first asserted bit found searching upward from (rr_ptr+1) and wrapping from N_SRC-1 to 0.
REQ-018 rr_ptr SHALL update to the granted index only on a cycle with a grant, and SHALL otherwise hold.
REQ-019 In MODE 1 with only one requester, that source SHALL win on every cycle, including repeated cycles.
REQ-020 When read_en is all zero, bus SHALL hold its previous value, grant SHALL be all zero, and bus_valid SHALL be 0.
REQ-021 grant SHALL be one-hot or all zero at all times.
REQ-022 conflict SHALL be 1 for one cycle for each sampled cycle in which popcount(read_en) >= 2, independent of MODE.
REQ-023 conflict_cnt SHALL increment by 1 on each conflict cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-024 clr_cnt high SHALL load conflict_cnt with 0 on the next edge and SHALL take precedence over a simultaneous increment.
REQ-025 A grant SHALL NOT be suppressed by a conflict; the arbitration winner SHALL still drive bus.
REQ-026 src_data of non-granted sources SHALL NOT affect any output.

Reset
REQ-027 While rst_n is low, outputs SHALL be forced immediately to bus=0, grant=0, bus_valid=0, conflict=0 and conflict_cnt=0.
REQ-028 While rst_n is low, rr_ptr SHALL be set to N_SRC-1 so that source 0 is searched first after reset.
REQ-029 A reset asserted mid-operation SHALL discard any pending arbitration result.
REQ-030 The first edge after rst_n deasserts SHALL perform normal arbitration on the sampled inputs.

Verification
REQ-031 MODE 0, DATA_W=16, N_SRC=12: read_en=0x00C, src2=0xAAAA, src3=0x5555 -> next cycle bus=0xAAAA, grant=0x004, bus_valid=1, conflict=1, conflict_cnt=1.
REQ-032 MODE 1: read_en held at 0x881 for 4 cycles after reset -> grants 0x001, 0x080, 0x800, 0x001 in successive cycles; conflict_cnt=4.
REQ-033 read_en=0x010 with src4=0x1234, then read_en=0 for 3 cycles -> bus stays 0x1234, bus_valid goes 1,0,0,0, grant goes 0x010,0,0,0.
REQ-034 CNT_W=2: 5 consecutive conflict cycles -> conflict_cnt reads 1,2,3,3,3; clr_cnt together with a conflict -> conflict_cnt=0 and conflict=1.
REQ-035 Assert rst_n low asynchronously between edges while bus=0xBEEF and conflict_cnt=7 -> outputs read 0 before the next edge; in MODE 1 with read_en=0xFFF after release, the first grant is 0x001.
REQ-036 Randomised read_en and src_data for 10k cycles in both MODEs -> grant is always one-hot or zero, bus equals the granted source's previous-cycle data, and conflict matches popcount >= 2.
